// File: rtl/serial_add_if.sv
// Handshake bundle between a sequencer and the bit-serial add/subtract controller.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: operands stream LSB-first through one shared 1-bit full adder,
// the carry is held between cycles and the result is assembled in a shift register.
module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic fa_s;
    logic fa_co;
    logic last_bit;

    full_add u_full_add (
        .a  (a_sr_reg[0]),
        .b  (b_sr_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                        a_sr_reg  <= bus.op_a;
                        b_sr_reg  <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry_reg <= bus.sub;
                        count_reg <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
                    carry_reg <= fa_co;
                    a_sr_reg  <= a_sr_reg >> 1;
                    b_sr_reg  <= b_sr_reg >> 1;
                    count_reg <= count_reg + CW'(1);
                    if (last_bit) begin
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        cout_reg  <= fa_co;
                        ovf_reg   <= carry_reg ^ fa_co;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vector table, corner sequences, random ops.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    serial_add_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         s;
        logic [7:0] exp_sum;
        bit         exp_cout;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference arithmetic on whole integers; results reduced to WIDTH bits afterwards.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit s,
                                  output logic [7:0] r, output bit c, output bit v);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sr = s ? sa - sb : sa + sb;
        v  = (sr > 127) || (sr < -128);
        c  = s ? (ua >= ub) : (ua + ub > 255);
        r  = s ? 8'(ua - ub) : 8'(ua + ub);
    endfunction

    // Present an op with start high for exactly one edge, then scramble the inputs.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit s);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        tick();
        bus.start = 1'b0;
        bus.op_a  = 8'($urandom);
        bus.op_b  = 8'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    // Cycle 1 is the cycle right after the accepting edge; returns the cycle done was seen in.
    task automatic wait_done(input int inj_cyc, input logic [7:0] inj_a,
                             output int cyc, output int bcnt, output bit viol);
        cyc  = 1;
        bcnt = 0;
        viol = 1'b0;
        while (!bus.done && cyc < 30) begin
            if (bus.busy && (bus.cout || bus.ovf)) viol = 1'b1;
            if (bus.busy) bcnt++;
            if (cyc == inj_cyc) begin
                bus.start = 1'b1;
                bus.op_a  = inj_a;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        if (bus.done && bus.busy) viol = 1'b1;
        bus.start = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                            input bit s, input int cyc, input int bcnt, input bit viol);
        logic [7:0] r;
        bit c, v;
        model(a, b, s, r, c, v);
        $display("op %s: %02h %s %02h -> sum=%02h cout=%0d ovf=%0d done_cycle=%0d",
                 name, a, s ? "-" : "+", b, bus.sum, bus.cout, bus.ovf, cyc);
        check({name, ".sum"}, 32'(bus.sum), 32'(r));
        check({name, ".cout"}, 32'(bus.cout), 32'(c));
        check({name, ".ovf"}, 32'(bus.ovf), 32'(v));
        check({name, ".latency"}, 32'(cyc), 32'(WIDTH + 1));
        check({name, ".busy_cycles"}, 32'(bcnt), 32'(WIDTH));
        check({name, ".flags_while_busy"}, 32'(viol), 32'(0));
    endtask

    initial begin
        int         cyc, bcnt, gap;
        bit         viol, seen;
        logic [7:0] ra, rb;
        bit         rs;

        vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset with start asserted: reset must win.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.op_a  = 8'hFF;
        bus.op_b  = 8'hFF;
        tick();
        tick();
        check("reset.busy", 32'(bus.busy), 32'(0));
        check("reset.done", 32'(bus.done), 32'(0));
        check("reset.sum", 32'(bus.sum), 32'(0));
        check("reset.cout", 32'(bus.cout), 32'(0));
        check("reset.ovf", 32'(bus.ovf), 32'(0));
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();

        // Directed vector table with spec-given expected values.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(0, 8'h00, cyc, bcnt, viol);
            $display("op vec%0d: sum=%02h cout=%0d ovf=%0d done_cycle=%0d",
                     i, bus.sum, bus.cout, bus.ovf, cyc);
            check($sformatf("vec%0d.sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d.cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d.ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d.latency", i), 32'(cyc), 32'(9));
            check($sformatf("vec%0d.busy_cycles", i), 32'(bcnt), 32'(8));
            tick();
            check($sformatf("vec%0d.done_pulse", i), 32'(bus.done), 32'(0));
            check($sformatf("vec%0d.sum_hold", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
        end

        // Start while busy is ignored, with no queued second op.
        launch(8'h11, 8'h22, 1'b0);
        wait_done(3, 8'hAA, cyc, bcnt, viol);
        check_op("ignore_busy_start", 8'h11, 8'h22, 1'b0, cyc, bcnt, viol);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("ignore_busy_start.no_queue", 32'(seen), 32'(0));

        // Reset mid-operation aborts it.
        launch(8'h3C, 8'h05, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", 32'(bus.busy), 32'(0));
        check("abort.done", 32'(bus.done), 32'(0));
        check("abort.sum", 32'(bus.sum), 32'(0));
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("abort.no_done", 32'(seen), 32'(0));
        launch(8'h01, 8'h01, 1'b0);
        wait_done(0, 8'h00, cyc, bcnt, viol);
        check_op("after_abort", 8'h01, 8'h01, 1'b0, cyc, bcnt, viol);

        // Back-to-back: start in the DONE cycle.
        tick();
        launch(8'h12, 8'h34, 1'b0);
        wait_done(0, 8'h00, cyc, bcnt, viol);
        check_op("b2b_first", 8'h12, 8'h34, 1'b0, cyc, bcnt, viol);
        launch(8'h50, 8'h60, 1'b1);
        wait_done(0, 8'h00, cyc, bcnt, viol);
        check_op("b2b_second", 8'h50, 8'h60, 1'b1, cyc, bcnt, viol);

        // Random ops; gap 0 means the next start lands in the DONE cycle.
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                tick();
                check("rand.done_pulse", 32'(bus.done), 32'(0));
                repeat (gap - 1) tick();
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            launch(ra, rb, rs);
            wait_done(0, 8'h00, cyc, bcnt, viol);
            check_op($sformatf("rand%0d", n), ra, rb, rs, cyc, bcnt, viol);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
